// File: rtl/instr_fetch_queue.sv
// Purpose : registered IF->DEC instruction FIFO carrying {instr, pc_plus4}; branch flush empties it.
// Latency : 1 cycle push-to-head (no bypass); head is read combinationally from storage.
// Backpr. : in_ready = !full from registered count only (full refuses a push even with a pop);
//           out_valid = !empty.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid / in_ready / in_instr / in_pc_plus4      : fetch side
//   out_valid / out_ready / out_instr / out_pc_plus4  : decode side (A64 NOP and 0 when empty)
//   flush                                             : drops every entry; wins over push/pop
//   count                                             : occupancy 0..DEPTH
//   bubble_cycles (only with FQ_BUBBLE_COUNT_EN)      : saturating count of decode-starved edges
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W-1:0]           in_instr,
  input  logic [PC_W-1:0]              in_pc_plus4,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [PC_W-1:0]              out_pc_plus4,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FQ_BUBBLE_COUNT_EN
  ,
  output logic [31:0]                  bubble_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'hD503201F);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;

  // Handshakes depend on registered occupancy only, never on the other side's request.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers are log2(DEPTH) bits and wrap on their own; count tells full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a flushed cycle must not leave the discarded entry behind.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc_plus4;
    end
  end

  // Empty queue presents a NOP so decode never sees stale or X data.
  always_comb begin
    out_instr    = NOP_INSTR;
    out_pc_plus4 = '0;
    if (out_valid) begin
      out_instr    = instr_mem[rd_ptr];
      out_pc_plus4 = pc_mem[rd_ptr];
    end
  end

`ifdef FQ_BUBBLE_COUNT_EN
  // Decode asked but nothing was there. Survives flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cycles <= '0;
    end else if (out_ready && !out_valid && (bubble_cycles != 32'hFFFF_FFFF)) begin
      bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a queue-based reference model plus per-cycle comparison,
// directed scenarios with literal expectations, then a long randomized run.
// Optional bubble counter is exercised when FQ_BUBBLE_COUNT_EN is defined.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc_plus4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc_plus4;
  logic        flush = 1'b0;
  logic [2:0]  count;
`ifdef FQ_BUBBLE_COUNT_EN
  logic [31:0] bubble_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  instr_fetch_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc_plus4  (in_pc_plus4),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc_plus4 (out_pc_plus4),
    .flush        (flush),
    .count        (count)
`ifdef FQ_BUBBLE_COUNT_EN
    ,
    .bubble_cycles(bubble_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t        mq[$];
  logic [31:0] m_bubble = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_bubble <= '0;
    end else begin
      if (out_ready && mq.size() == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble <= m_bubble + 1;
      if (flush) begin
        mq.delete();
      end else begin
        bit do_push, do_pop;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{instr: in_instr, pc: in_pc_plus4});
      end
    end
  end

  // Outputs depend only on registered state; check them mid-cycle every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count",     64'(count),     64'(mq.size()));
      check("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("m_in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
      check("m_out_instr", 64'(out_instr), 64'((mq.size() != 0) ? mq[0].instr : NOP));
      check("m_out_pc",    out_pc_plus4,   (mq.size() != 0) ? mq[0].pc : 64'd0);
`ifdef FQ_BUBBLE_COUNT_EN
      check("m_bubble",    64'(bubble_cycles), 64'(m_bubble));
`endif
    end
  end

  // Inputs change just after the rising edge so they are stable through the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    out_ready = 1'b0;
  endtask

  initial begin
    int idx, got;
    bit pop_now;

    // ---- reset held 2 cycles with in_valid=1 ----
    reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'h1111_1111; in_pc_plus4 = 64'h10;
    step();
    chk_en = 1'b1;
    step();
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_instr", 64'(out_instr), 64'hD503201F);
    check("rst_out_pc",    out_pc_plus4,   64'd0);
    reset = 1'b1;
    in_instr = 32'h8B020020; in_pc_plus4 = 64'h4;
    step();
    in_valid = 1'b0;
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_instr", 64'(out_instr), 64'h8B020020);
    check("first_pc",    out_pc_plus4,   64'h4);
    drain();

    // ---- fill past full ----
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_instr = 32'(k); in_pc_plus4 = 64'(4 * k);
      step();
      if (k == 4) begin
        check("fill_count4",   64'(count),    64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
      end
    end
    check("fill_count_after5", 64'(count), 64'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("fill_pop_order", 64'(out_instr), 64'(k));
      step();
    end
    check("fill_empty_valid", 64'(out_valid), 64'd0);
    idle();

    // ---- simultaneous push/pop ----
    in_valid = 1'b1; in_instr = 32'hA; in_pc_plus4 = 64'h100; step();
    in_instr = 32'hB; in_pc_plus4 = 64'h104; step();
    check("sim_count2", 64'(count), 64'd2);
    in_instr = 32'hC; in_pc_plus4 = 64'h108; out_ready = 1'b1;
    step();
    check("sim_count_same", 64'(count),     64'd2);
    check("sim_head_b",     64'(out_instr), 64'hB);
    in_valid = 1'b0;
    step();
    check("sim_head_c",  64'(out_instr), 64'hC);
    check("sim_pc_c",    out_pc_plus4,   64'h108);
    drain();

    // ---- flush priority ----
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_instr = 32'h50 + 32'(k); in_pc_plus4 = 64'h200 + 64'(4 * k); step();
    end
    check("fl_count3", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hDEAD; in_pc_plus4 = 64'hBAD;
    step();
    idle();
    check("fl_count0",   64'(count),     64'd0);
    check("fl_valid0",   64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready),  64'd1);
    check("fl_nop",      64'(out_instr), 64'hD503201F);
    in_valid = 1'b1; in_instr = 32'hF00D; in_pc_plus4 = 64'h300;
    step();
    in_valid = 1'b0;
    check("fl_next_head", 64'(out_instr), 64'hF00D);
    check("fl_next_cnt",  64'(count),     64'd1);
    drain();

    // ---- wrap-around stream with toggling out_ready ----
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      in_valid    = (idx < 10);
      in_instr    = 32'hE000_0000 + 32'(idx);
      in_pc_plus4 = 64'(4 * (idx + 1));
      out_ready   = ~out_ready;
      pop_now     = out_valid && out_ready;
      if (pop_now) begin
        check("wrap_pc",    out_pc_plus4,   64'(4 * (got + 1)));
        check("wrap_instr", 64'(out_instr), 64'(32'hE000_0000 + 32'(got)));
        got++;
      end
      if (in_valid && in_ready) idx++;
      step();
      check("wrap_cnt_le4", 64'(count <= 3'd4), 64'd1);
    end
    check("wrap_all_out", 64'(got), 64'd10);
    drain();

`ifdef FQ_BUBBLE_COUNT_EN
    // ---- bubble counter ----
    idle();
    reset = 1'b0; step(); reset = 1'b1; step();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    out_ready = 1'b0;
    check("bub_7", 64'(bubble_cycles), 64'd7);
    flush = 1'b1; step(); flush = 1'b0;
    check("bub_flush_7", 64'(bubble_cycles), 64'd7);
    reset = 1'b0; #1;
    check("bub_reset_0", 64'(bubble_cycles), 64'd0);
    step(); reset = 1'b1;
`endif

    // ---- randomized run ----
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int mode;
      mode = cyc / 500;
      in_valid    = ($urandom_range(0, 3) != 0) ^ (mode == 3);
      out_ready   = (mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      in_instr    = $urandom;
      in_pc_plus4 = {$urandom, $urandom};
      flush       = ($urandom_range(0, 19) == 0);
      reset       = ($urandom_range(0, 249) != 0);
      step();
    end
    idle();
    reset = 1'b1;
    step();
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
